ipv4_header_tx_scheduler: RTL and testbench

IPV4_HEADER_TX_SCHEDULER -- requirements
Module: ipv4_header_tx_scheduler

---
 rtl/ipv4_pkg.sv | 56 +++++
 rtl/ipv4_rr_arbiter.sv | 28 ++
 rtl/ipv4_header_tx_scheduler.sv | 121 ++++++++++++
 tb/tb_ipv4_header_tx_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_pkg.sv
// Shared types and helpers for the IPv4 header transmit scheduler.
// Holds the FSM state encoding, the 144-bit header layout and the checksum arithmetic.
package ipv4_pkg;

  localparam int HDR_SUM_WORDS = 9;
  localparam int HDR_BEATS     = 5;
  localparam int HDR_BITS      = 144;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_FOLD,
    ST_EMIT
  } state_t;

  typedef struct packed {
    logic [7:0]  ver_ihl;
    logic [7:0]  tos;
    logic [15:0] len;
    logic [15:0] id;
    logic [15:0] flags_frag;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
  } ipv4_hdr_t;

  // 16-bit words of the header in checksum order; the checksum field itself counts as zero.
  function automatic logic [15:0] sum_word(input ipv4_hdr_t h, input logic [3:0] idx);
    logic [15:0] w;
    w = '0;
    case (idx)
      4'd0: w = {h.ver_ihl, h.tos};
      4'd1: w = h.len;
      4'd2: w = h.id;
      4'd3: w = h.flags_frag;
      4'd4: w = {h.ttl, h.proto};
      4'd5: w = h.src[31:16];
      4'd6: w = h.src[15:0];
      4'd7: w = h.dst[31:16];
      4'd8: w = h.dst[15:0];
      default: w = '0;
    endcase
    return w;
  endfunction

  // Two end-around-carry folds always suffice for a 20-bit sum of nine words.
  function automatic logic [15:0] fold_csum(input logic [19:0] acc);
    logic [16:0] s1;
    logic [15:0] s2;
    s1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    s2 = s1[15:0] + {15'b0, s1[16]};
    return ~s2;
  endfunction

endpackage

// File: rtl/ipv4_rr_arbiter.sv
// Round-robin grant: first asserted request at or after the pointer, wrapping.
// Purely combinational; the owner of the pointer decides when a grant is taken.
module ipv4_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_any = 1'b1;
        o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/ipv4_header_tx_scheduler.sv
// Arbitrates IPv4 header requesters, computes the header checksum over nine cycles,
// then streams the 20-byte header as five 32-bit beats on a valid/ready channel.
module ipv4_header_tx_scheduler
  import ipv4_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic [NUM_REQ-1:0]                 REQ_VALID,
  output logic [NUM_REQ-1:0]                 REQ_READY,
  input  logic [NUM_REQ-1:0][HDR_BITS-1:0]   REQ_HDR,
  output logic [31:0]                        HDR_TDATA,
  output logic                               HDR_TVALID,
  input  logic                               HDR_TREADY,
  output logic                               HDR_TLAST,
  output logic [ID_W-1:0]                    HDR_TID,
  output logic                               BUSY
);

  state_t          r_state;
  ipv4_hdr_t       r_hdr;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_tid;
  logic [19:0]     r_acc;
  logic [15:0]     r_csum;
  logic [3:0]      r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_any;
  logic               w_emit;
  logic [31:0]        w_beat_data;

  ipv4_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (REQ_VALID),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_emit    = (r_state == ST_EMIT);

  // The grant is combinational, so it must also be masked while reset is held.
  assign REQ_READY  = (r_state == ST_IDLE && RESET_N) ? w_grant : '0;
  assign HDR_TVALID = w_emit;
  assign HDR_TLAST  = w_emit && (r_cnt == 4'(HDR_BEATS - 1));
  assign HDR_TDATA  = w_emit ? w_beat_data : '0;
  assign HDR_TID    = r_tid;
  assign BUSY       = (r_state != ST_IDLE);

  always_comb begin
    w_beat_data = '0;
    case (r_cnt)
      4'd0: w_beat_data = {r_hdr.ver_ihl, r_hdr.tos, r_hdr.len};
      4'd1: w_beat_data = {r_hdr.id, r_hdr.flags_frag};
      4'd2: w_beat_data = {r_hdr.ttl, r_hdr.proto, r_csum};
      4'd3: w_beat_data = r_hdr.src;
      4'd4: w_beat_data = r_hdr.dst;
      default: w_beat_data = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_hdr   <= '0;
      r_ptr   <= '0;
      r_tid   <= '0;
      r_acc   <= '0;
      r_csum  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_hdr   <= REQ_HDR[w_idx];
            r_tid   <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SUM;
          end
        end
        ST_SUM: begin
          r_acc <= r_acc + {4'b0, sum_word(r_hdr, r_cnt)};
          if (r_cnt == 4'(HDR_SUM_WORDS - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_FOLD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_FOLD: begin
          r_csum  <= fold_csum(r_acc);
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (HDR_TREADY) begin
            if (r_cnt == 4'(HDR_BEATS - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_header_tx_scheduler.sv
// Self-checking bench for ipv4_header_tx_scheduler: directed header cases plus randomized
// traffic, compared against a one's-complement checksum and round-robin model.
module tb_ipv4_header_tx_scheduler;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                        CLK;
  logic                        RESET_N;
  logic [NUM_REQ-1:0]          REQ_VALID;
  logic [NUM_REQ-1:0]          REQ_READY;
  logic [NUM_REQ-1:0][143:0]   REQ_HDR;
  logic [31:0]                 HDR_TDATA;
  logic                        HDR_TVALID;
  logic                        HDR_TREADY;
  logic                        HDR_TLAST;
  logic [ID_W-1:0]             HDR_TID;
  logic                        BUSY;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  ipv4_header_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_HDR    (REQ_HDR),
    .HDR_TDATA  (HDR_TDATA),
    .HDR_TVALID (HDR_TVALID),
    .HDR_TREADY (HDR_TREADY),
    .HDR_TLAST  (HDR_TLAST),
    .HDR_TID    (HDR_TID),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Internet checksum by repeated end-around carry over the nine header halfwords.
  function automatic logic [15:0] model_csum(input logic [143:0] h);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 9; i++) s += h[i*16 +: 16];
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  function automatic logic [31:0] model_beat(input logic [143:0] h, input int b);
    logic [159:0] full;
    full = {h[143:64], model_csum(h), h[63:0]};
    return full[159 - 32*b -: 32];
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_tvalid"}, 64'(HDR_TVALID), 0);
    check({tag, "_tlast"},  64'(HDR_TLAST),  0);
    check({tag, "_tdata"},  64'(HDR_TDATA),  0);
    check({tag, "_tid"},    64'(HDR_TID),    0);
    check({tag, "_busy"},   64'(BUSY),       0);
    check({tag, "_ready"},  64'(REQ_READY),  0);
  endtask

  // Runs one header from grant to final beat. Entered and left just after a falling edge.
  task automatic do_header(input logic [NUM_REQ-1:0] mask, input int stall_beat,
                           input int stall_len, input bit rand_ready, input int abort_beat,
                           output int wait_cyc, output logic [31:0] b3, output int tid_seen);
    int g, cnt, beat, guard, stalls;
    logic [143:0] h;
    bit rdy;
    REQ_VALID = mask;
    wait_cyc = 0; b3 = '0; tid_seen = -1; g = -1;
    #1;
    while (REQ_READY == '0 && wait_cyc < 40) begin
      @(negedge CLK); #1; wait_cyc++;
    end
    if (REQ_READY == '0) begin
      check("grant_timeout", 1, 0);
      return;
    end
    for (int k = 0; k < NUM_REQ; k++)
      if (g < 0 && mask[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    check("grant_onehot", 64'(REQ_READY), 64'(1) << g);
    h = REQ_HDR[g];
    m_ptr = (g + 1) % NUM_REQ;
    cnt = 0;
    do begin
      @(negedge CLK);
      REQ_VALID = NUM_REQ'($urandom);
      #1; cnt++;
      if (!HDR_TVALID) begin
        check("busy_ready_low", 64'(REQ_READY), 0);
        check("busy_high", 64'(BUSY), 1);
      end
    end while (!HDR_TVALID && cnt < 30);
    check("latency", 64'(cnt), 11);
    beat = 0; guard = 0; stalls = 0;
    while (beat < 5 && guard < 200) begin
      check("tvalid", 64'(HDR_TVALID), 1);
      check("tdata", 64'(HDR_TDATA), 64'(model_beat(h, beat)));
      check("tlast", 64'(HDR_TLAST), 64'(beat == 4));
      check("tid", 64'(HDR_TID), 64'(g));
      check("emit_ready_low", 64'(REQ_READY), 0);
      if (beat == 2) b3 = HDR_TDATA;
      tid_seen = int'(HDR_TID);
      if (beat == abort_beat) begin
        REQ_VALID = '1;
        RESET_N = 1'b0;
        #1;
        check_quiet("abort");
        m_ptr = 0;
        repeat (2) begin
          @(negedge CLK); #1;
          check("abort_hold_tvalid", 64'(HDR_TVALID), 0);
        end
        REQ_VALID = '0;
        RESET_N = 1'b1;
        return;
      end
      if (beat == stall_beat && stalls < stall_len) begin
        rdy = 1'b0; stalls++;
      end else begin
        rdy = rand_ready ? 1'($urandom) : 1'b1;
      end
      HDR_TREADY = rdy;
      @(negedge CLK); #1;
      if (rdy) beat++;
      guard++;
    end
    check("beats_done", 64'(beat), 5);
    check("post_busy", 64'(BUSY), 0);
    check("post_tvalid", 64'(HDR_TVALID), 0);
    REQ_VALID = '0;
    HDR_TREADY = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    int wc, tid;
    logic [31:0] b3;
    logic [NUM_REQ-1:0] m;
    logic [143:0] hd;

    RESET_N = 1'b0; REQ_VALID = '1; HDR_TREADY = 1'b1; REQ_HDR = '0;
    #2;
    check_quiet("reset");
    @(negedge CLK); @(negedge CLK);
    RESET_N = 1'b1;
    REQ_VALID = '0;
    #1;

    // Reference header on requester 0.
    REQ_HDR[0] = 144'h4500_0073_0000_4000_4011_C0A80001_C0A800C7;
    do_header(2'b01, -1, 0, 1'b0, -1, wc, b3, tid);
    check("ref_beat3", 64'(b3), 64'h4011B861);

    REQ_HDR[1] = '0;
    do_header(2'b10, -1, 0, 1'b0, -1, wc, b3, tid);
    check("zero_csum", 64'(b3[15:0]), 64'hFFFF);

    REQ_HDR[0] = '1;
    do_header(2'b01, -1, 0, 1'b0, -1, wc, b3, tid);
    check("ones_csum", 64'(b3[15:0]), 64'h0000);

    // Backpressure on beat 3 for three cycles.
    REQ_HDR[0] = 144'h4500_0073_0000_4000_4011_C0A80001_C0A800C7;
    do_header(2'b01, 2, 3, 1'b0, -1, wc, b3, tid);
    check("stall_beat3", 64'(b3), 64'h4011B861);

    // Reset during beat 2 abandons the header; the next grant favours requester 0.
    REQ_HDR[1] = 144'h4500_0014_1234_0000_4006_0A000001_0A000002;
    do_header(2'b11, -1, 0, 1'b0, 1, wc, b3, tid);
    @(negedge CLK); #1;
    check("after_abort_quiet", 64'(HDR_TVALID), 0);

    // Both requesters held valid: alternating owners, back-to-back at 16-cycle period.
    for (int i = 0; i < 4; i++) begin
      do_header(2'b11, -1, 0, 1'b0, -1, wc, b3, tid);
      check("rr_tid", 64'(tid), 64'(i % 2));
      if (i > 0) check("rr_gap", 64'(wc), 0);
    end

    // Randomized traffic with random ready and random idle gaps.
    for (int i = 0; i < 30; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        for (int w = 0; w < 5; w++) hd[w*32 +: 32] = $urandom;
        REQ_HDR[r] = hd;
      end
      do m = NUM_REQ'($urandom); while (m == '0);
      repeat ($urandom_range(0, 3)) begin @(negedge CLK); #1; end
      do_header(m, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b1, -1,
                wc, b3, tid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
